// File: rtl/dmem_responder.sv
// Single-port data memory responder: byte/half/word loads and stores with configurable wait states.
// Optional macro DMEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into faults.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic accept;

  logic        we_p0;
  logic [1:0]  size_p0;
  logic        uns_p0;
  logic [31:0] addr_p0;
  logic [31:0] wdata_p0;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word;
  logic          oor, misalign, err, commit;
  logic [31:0]   wmask, wword;

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] ofs, input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] sx;
    logic [31:0]        res;
    b = word[8*ofs +: 8];
    h = word[16*ofs[1] +: 16];
    res = '0;
    case (size)
      2'b00: begin
        sx  = b;
        res = uns ? {24'd0, b} : sx;
      end
      2'b01: begin
        sx  = h;
        res = uns ? {16'd0, h} : sx;
      end
      2'b10:   res = word;
      default: res = '0;
    endcase
    return res;
  endfunction

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_STATES > 0) begin
            state_nxt = WAIT;
            cnt_nxt   = WAIT_INIT;
          end else begin
            state_nxt = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture: held stable for the whole transaction, inputs ignored afterwards
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= req_we;
      size_p0  <= req_size;
      uns_p0   <= req_unsigned;
      addr_p0  <= req_addr;
      wdata_p0 <= req_wdata;
    end
  end

  assign word_idx = addr_p0[AW+1:2];
  assign oor      = |addr_p0[31:AW+2];
  assign rd_word  = mem[word_idx];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign = ((size_p0 == 2'b01) && addr_p0[0]) ||
                    ((size_p0 == 2'b10) && (addr_p0[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign err = oor || (size_p0 == 2'b11) || misalign;

  assign rsp_valid = (state == RESP);
  assign rsp_err   = rsp_valid && err;
  assign rsp_rdata = (rsp_valid && !err && !we_p0) ?
                     load_extend(rd_word, size_p0, addr_p0[1:0], uns_p0) : 32'd0;

  always_comb begin
    wmask = '0;
    wword = '0;
    case (size_p0)
      2'b00: begin
        wmask = 32'h0000_00FF << (8 * addr_p0[1:0]);
        wword = {4{wdata_p0[7:0]}};
      end
      2'b01: begin
        wmask = 32'h0000_FFFF << (16 * addr_p0[1]);
        wword = {2{wdata_p0[15:0]}};
      end
      2'b10: begin
        wmask = 32'hFFFF_FFFF;
        wword = wdata_p0;
      end
      default: begin
        wmask = '0;
        wword = '0;
      end
    endcase
  end

  // Store commits on the edge leaving RESP; an async reset drops RESP before that edge
  assign commit = (state == RESP) && we_p0 && !err;

  always_ff @(posedge clk) begin
    if (commit) mem[word_idx] <= (rd_word & ~wmask) | (wword & wmask);
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed stores/loads, faults, back-to-back and reset abort.
module tb_dmem_responder;
  localparam int DEPTH_WORDS = 256;
  localparam int WAIT_STATES = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   nchk = 0;
  int   npass = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  int   prev_acc = 0;
  bit   have_prev = 0;
  bit   b2b = 0;

  dmem_responder #(.DEPTH_WORDS(DEPTH_WORDS), .WAIT_STATES(WAIT_STATES)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Acceptance observer
  always @(posedge clk) begin
    if (reset && req_valid && req_ready) begin
      acc_q.push_back(cyc);
      if (b2b && have_prev) check("b2b_spacing", cyc - prev_acc, 2 + WAIT_STATES);
      prev_acc  = cyc;
      have_prev = 1;
      acc_cnt++;
    end
  end

  // Response monitor
  always @(negedge clk) begin
    if (reset) begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
          if (acc_q.size() != 0) check("rsp_latency", cyc - acc_q.pop_front(), WAIT_STATES + 1);
        end
      end else begin
        check("idle_rdata", rsp_rdata, 32'd0);
        check("idle_err", {31'd0, rsp_err}, 32'd0);
      end
      if (busy) check("ready_while_busy", {31'd0, req_ready}, 32'd0);
    end
  end

  task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
  endtask

  task automatic scramble();
    req_valid    = 1'b0;
    req_we       = ~req_we;
    req_size     = 2'b11;
    req_unsigned = ~req_unsigned;
    req_addr     = 32'hFFFF_FFFC;
    req_wdata    = 32'h5A5A_5A5A;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("rsp_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic xfer(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err);
    int n = 0;
    exp_q.push_back('{rdata: exp_rdata, err: exp_err});
    @(negedge clk);
    drive(we, size, uns, addr, wdata);
    while (!req_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("accept_timeout", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 scramble();
    wait_drain();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    #1;
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_rdata", rsp_rdata, 32'd0);
    check("reset_err", {31'd0, rsp_err}, 32'd0);
    check("reset_ready", {31'd0, req_ready}, 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // word store/load
    xfer(1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF, 32'h0, 0);
    xfer(0, 2'b10, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0);

    // byte store and sign/zero extension
    xfer(1, 2'b10, 0, 32'h20, 32'h4433_2211, 32'h0, 0);
    xfer(1, 2'b00, 0, 32'h21, 32'hABCD_EF80, 32'h0, 0);
    xfer(0, 2'b00, 0, 32'h21, 32'h0, 32'hFFFF_FF80, 0);
    xfer(0, 2'b00, 1, 32'h21, 32'h0, 32'h0000_0080, 0);
    xfer(0, 2'b10, 0, 32'h20, 32'h0, 32'h4433_8011, 0);
    xfer(0, 2'b00, 0, 32'h23, 32'h0, 32'h0000_0044, 0);

    // half store and extension
    xfer(1, 2'b01, 0, 32'h22, 32'h0000_F00D, 32'h0, 0);
    xfer(0, 2'b01, 0, 32'h22, 32'h0, 32'hFFFF_F00D, 0);
    xfer(0, 2'b01, 1, 32'h22, 32'h0, 32'h0000_F00D, 0);
    xfer(0, 2'b10, 0, 32'h20, 32'h0, 32'hF00D_8011, 0);

    // out of range and reserved size
    xfer(1, 2'b10, 0, 32'h0, 32'hCAFE_F00D, 32'h0, 0);
    xfer(1, 2'b10, 0, 32'h400, 32'h1111_2222, 32'h0, 1);
    xfer(0, 2'b10, 0, 32'h0, 32'h0, 32'hCAFE_F00D, 0);
    xfer(0, 2'b10, 0, 32'h400, 32'h0, 32'h0, 1);
    xfer(0, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1);
    xfer(1, 2'b11, 0, 32'h0, 32'h0, 32'h0, 1);
    xfer(0, 2'b10, 0, 32'h0, 32'h0, 32'hCAFE_F00D, 0);

    // misaligned accesses
`ifdef DMEM_MISALIGN_TRAP_EN
    xfer(0, 2'b10, 0, 32'h12, 32'h0, 32'h0, 1);
    xfer(1, 2'b01, 0, 32'h23, 32'h0000_1234, 32'h0, 1);
    xfer(0, 2'b10, 0, 32'h20, 32'h0, 32'hF00D_8011, 0);
`else
    xfer(0, 2'b10, 0, 32'h12, 32'h0, 32'hDEAD_BEEF, 0);
    xfer(1, 2'b01, 0, 32'h23, 32'h0000_1234, 32'h0, 0);
    xfer(0, 2'b10, 0, 32'h20, 32'h0, 32'h1234_8011, 0);
`endif

    // back-to-back with req_valid held high
    begin
      int base;
      int n = 0;
      for (int i = 0; i < 3; i++) exp_q.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b0});
      base = acc_cnt;
      have_prev = 0;
      b2b = 1;
      @(negedge clk);
      drive(0, 2'b10, 0, 32'h10, 32'h0);
      while (acc_cnt - base < 3 && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("b2b_accepts", acc_cnt - base, 3);
      scramble();
      wait_drain();
      b2b = 0;
    end

    // reset during WAIT aborts the store
    xfer(1, 2'b10, 0, 32'h30, 32'h0BAD_CAFE, 32'h0, 0);
    @(negedge clk);
    drive(1, 2'b10, 0, 32'h30, 32'h1234_5678);
    @(posedge clk);
    #1 scramble();
    check("wait_busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    acc_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    xfer(0, 2'b10, 0, 32'h30, 32'h0, 32'h0BAD_CAFE, 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
